// File: rtl/bus_mem_server_pkg.sv
// Shared types and constants for the byte-serial memory server.
// State/kind encodings are also visible to the bench through dbg_state.
package bus_mem_server_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      ADDR_LO    = 3'd1,
      MAR_DECIDE = 3'd2,
      WR_LO      = 3'd3,
      WAIT       = 3'd4,
      SEND       = 3'd5
   } srv_state_t;

   typedef enum logic {
      FETCH = 1'b0,
      MEM   = 1'b1
   } srv_kind_t;

   localparam int FETCH_BYTES = 4;
   localparam int LOAD_BYTES  = 2;

   // Response length for a read of the given kind.
   function automatic logic [2:0] kind_bytes(input srv_kind_t kind);
      return (kind == FETCH) ? 3'(FETCH_BYTES) : 3'(LOAD_BYTES);
   endfunction

   // True when only the strobe belonging to this request kind is high.
   function automatic logic strobe_matches(input srv_kind_t kind,
                                           input logic pc,
                                           input logic mar,
                                           input logic mdr);
      if (kind == FETCH) return pc & ~mar & ~mdr;
      return mar & ~pc & ~mdr;
   endfunction

endpackage

// File: rtl/bus_mem_server_ram.sv
// Word RAM for the memory server: one synchronous write port and two
// asynchronous read ports (request word and the word after it).
module server_ram #(
   parameter int ADDR_W = 8
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [15:0]       i_wdata,
   input  logic [ADDR_W-1:0] i_raddr_a,
   input  logic [ADDR_W-1:0] i_raddr_b,
   output logic [15:0]       o_rdata_a,
   output logic [15:0]       o_rdata_b
);

   logic [15:0] r_mem [0:(1<<ADDR_W)-1];

   // Contents are intentionally not reset; the host preloads them.
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata_a = r_mem[i_raddr_a];
   assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/bus_mem_server.sv
// On-chip stand-in for the byte-serial host: decodes core bus strobes,
// serves fetches/loads/stores from server_ram and returns bytes on in_bus.
module bus_mem_server
   import bus_mem_server_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int RESP_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              halt,
   input  logic              bus_pc,
   input  logic              bus_mar,
   input  logic              bus_mdr,
   input  logic [7:0]        out_bus,
   output logic [7:0]        in_bus,
   output logic              ard_data_ready,
   output logic              ard_receive_ready,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [15:0]       prog_data,
   output logic              protocol_err,
   output srv_state_t        dbg_state
);

   srv_state_t        r_state;
   srv_kind_t         r_kind;
   logic [7:0]        r_addr_hi;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_data_hi;
   logic [3:0]        r_wait;
   logic [2:0]        r_nbytes;
   logic [2:0]        r_idx;
   logic [7:0]        r_in_bus;
   logic              r_data_ready;
   logic              r_err;

   logic              w_any_strobe;
   logic              w_one_strobe;
   logic              w_same_strobe;
   logic              w_store_we;
   logic              w_ram_we;
   logic [ADDR_W-1:0] w_waddr;
   logic [15:0]       w_wdata;
   logic [ADDR_W-1:0] w_addr_next;
   logic [15:0]       w_rd_a;
   logic [15:0]       w_rd_b;
   logic [7:0]        w_tx_byte;

   assign w_any_strobe  = bus_pc | bus_mar | bus_mdr;
   assign w_one_strobe  = $onehot({bus_pc, bus_mar, bus_mdr});
   assign w_same_strobe = strobe_matches(r_kind, bus_pc, bus_mar, bus_mdr);

   // The store lands on the edge that ends the data-low-byte cycle; a
   // simultaneous preload write to the RAM takes priority.
   assign w_store_we  = (r_state == WR_LO) && bus_mdr && !halt;
   assign w_ram_we    = prog_we | w_store_we;
   assign w_waddr     = prog_we ? prog_addr : r_addr;
   assign w_wdata     = prog_we ? prog_data : {r_data_hi, out_bus};
   assign w_addr_next = r_addr + ADDR_W'(1);

   server_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .i_clk     (clk),
      .i_we      (w_ram_we),
      .i_waddr   (w_waddr),
      .i_wdata   (w_wdata),
      .i_raddr_a (r_addr),
      .i_raddr_b (w_addr_next),
      .o_rdata_a (w_rd_a),
      .o_rdata_b (w_rd_b)
   );

   always_comb begin
      w_tx_byte = 8'h00;
      case (r_idx)
         3'd0:    w_tx_byte = w_rd_a[15:8];
         3'd1:    w_tx_byte = w_rd_a[7:0];
         3'd2:    w_tx_byte = w_rd_b[15:8];
         default: w_tx_byte = w_rd_b[7:0];
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_kind       <= FETCH;
         r_addr_hi    <= 8'h00;
         r_addr       <= '0;
         r_data_hi    <= 8'h00;
         r_wait       <= 4'd0;
         r_nbytes     <= 3'd0;
         r_idx        <= 3'd0;
         r_in_bus     <= 8'h00;
         r_data_ready <= 1'b0;
         r_err        <= 1'b0;
      end else if (halt) begin
         // Halt aborts everything, drops a pending store and masks strobes.
         r_state      <= IDLE;
         r_in_bus     <= 8'h00;
         r_data_ready <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_one_strobe && !bus_mdr) begin
                  r_addr_hi <= out_bus;
                  r_kind    <= bus_pc ? FETCH : MEM;
                  r_state   <= ADDR_LO;
               end else if (w_any_strobe) begin
                  r_err <= 1'b1;
               end
            end
            ADDR_LO: begin
               if (w_same_strobe) begin
                  r_addr <= ADDR_W'({r_addr_hi, out_bus});
                  if (r_kind == FETCH) begin
                     r_wait   <= 4'(RESP_LAT);
                     r_nbytes <= kind_bytes(FETCH);
                     r_idx    <= 3'd0;
                     r_state  <= WAIT;
                  end else begin
                     r_state <= MAR_DECIDE;
                  end
               end else begin
                  r_err   <= 1'b1;
                  r_state <= IDLE;
               end
            end
            MAR_DECIDE: begin
               if (bus_mdr) begin
                  r_data_hi <= out_bus;
                  r_state   <= WR_LO;
               end else begin
                  r_wait   <= 4'(RESP_LAT);
                  r_nbytes <= kind_bytes(MEM);
                  r_idx    <= 3'd0;
                  r_state  <= WAIT;
               end
            end
            WR_LO: begin
               if (!bus_mdr) r_err <= 1'b1;
               r_state <= IDLE;
            end
            WAIT: begin
               if (w_any_strobe) r_err <= 1'b1;
               if (r_wait <= 4'd1) begin
                  r_in_bus     <= w_tx_byte;
                  r_data_ready <= 1'b1;
                  r_idx        <= r_idx + 3'd1;
                  r_state      <= SEND;
               end else begin
                  r_wait <= r_wait - 4'd1;
               end
            end
            SEND: begin
               if (w_any_strobe) r_err <= 1'b1;
               if (r_idx == r_nbytes) begin
                  r_in_bus     <= 8'h00;
                  r_data_ready <= 1'b0;
                  r_state      <= IDLE;
               end else begin
                  r_in_bus <= w_tx_byte;
                  r_idx    <= r_idx + 3'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ard_receive_ready = ((r_state == IDLE) || (r_state == ADDR_LO) ||
                               (r_state == MAR_DECIDE) || (r_state == WR_LO)) && !halt;

   assign in_bus         = r_in_bus;
   assign ard_data_ready = r_data_ready;
   assign protocol_err   = r_err;
   assign dbg_state      = r_state;

endmodule

// File: tb/tb_bus_mem_server.sv
// Bench for bus_mem_server: vector table of fetch/load requests plus
// hand-written store, protocol-error, halt and reset sequences.
module tb_bus_mem_server;
   import bus_mem_server_pkg::*;

   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              halt = 1'b0;
   logic              bus_pc = 1'b0, bus_mar = 1'b0, bus_mdr = 1'b0;
   logic [7:0]        out_bus = 8'h00;
   logic [7:0]        in_bus;
   logic              ard_data_ready, ard_receive_ready, protocol_err;
   logic              prog_we = 1'b0;
   logic [ADDR_W-1:0] prog_addr = '0;
   logic [15:0]       prog_data = 16'h0000;
   srv_state_t        dbg_state;

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q[$];

   bus_mem_server #(.ADDR_W(ADDR_W), .RESP_LAT(1)) dut (
      .clk(clk), .rst(rst), .halt(halt),
      .bus_pc(bus_pc), .bus_mar(bus_mar), .bus_mdr(bus_mdr),
      .out_bus(out_bus), .in_bus(in_bus),
      .ard_data_ready(ard_data_ready), .ard_receive_ready(ard_receive_ready),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .protocol_err(protocol_err), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every valid response byte must match the queue head.
   always @(negedge clk) begin
      if (rst && ard_data_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %h expected none at %0t", in_bus, $time);
         end else begin
            check("resp_byte", {8'h00, in_bus}, {8'h00, exp_q.pop_front()});
         end
      end
   end

   task automatic drive(input logic pc, input logic mar, input logic mdr, input logic [7:0] b);
      bus_pc = pc; bus_mar = mar; bus_mdr = mdr; out_bus = b;
      @(posedge clk); #1;
   endtask

   task automatic idle_inputs();
      bus_pc = 1'b0; bus_mar = 1'b0; bus_mdr = 1'b0; out_bus = 8'h00;
   endtask

   task automatic prog_write(input logic [ADDR_W-1:0] a, input logic [15:0] d);
      prog_we = 1'b1; prog_addr = a; prog_data = d;
      @(posedge clk); #1;
      prog_we = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      halt = 1'b0;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   // Issues a two-byte address request, then watches 30 cycles; cycle 0 is
   // the one carrying the address low byte.
   task automatic do_req(input logic fetch, input logic [15:0] addr,
                         output int first, output int cnt);
      first = -1;
      cnt = 0;
      drive(fetch, !fetch, 1'b0, addr[15:8]);
      drive(fetch, !fetch, 1'b0, addr[7:0]);
      idle_inputs();
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (ard_data_ready) begin
            if (first < 0) first = c;
            cnt++;
         end
         @(posedge clk); #1;
      end
   endtask

   typedef struct {
      logic        fetch;
      logic [15:0] addr;
      int          nbytes;
      logic [31:0] exp_bytes;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int first, cnt;
      vecs[0] = '{1'b1, 16'h0010, 4, 32'h1234ABCD};
      vecs[1] = '{1'b0, 16'h0011, 2, 32'hABCD0000};
      vecs[2] = '{1'b1, 16'h01FF, 4, 32'hCAFEF00D};
      vecs[3] = '{1'b0, 16'h0120, 2, 32'h55660000};
      vecs[4] = '{1'b1, 16'h0020, 4, 32'h55667788};
      vecs[5] = '{1'b0, 16'h00FF, 2, 32'hCAFE0000};

      // Reset values while reset is held
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_bus", {8'h00, in_bus}, 16'h0000);
      check("rst_data_ready", {15'd0, ard_data_ready}, 16'd0);
      check("rst_err", {15'd0, protocol_err}, 16'd0);
      check("rst_recv_ready", {15'd0, ard_receive_ready}, 16'd1);
      check("rst_state", {13'd0, dbg_state}, {13'd0, IDLE});
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;

      prog_write(8'h10, 16'h1234);
      prog_write(8'h11, 16'hABCD);
      prog_write(8'h20, 16'h5566);
      prog_write(8'h21, 16'h7788);
      prog_write(8'hFF, 16'hCAFE);
      prog_write(8'h00, 16'hF00D);
      prog_write(8'h30, 16'hC3A5);

      foreach (vecs[v]) begin
         for (int i = 0; i < vecs[v].nbytes; i++)
            exp_q.push_back(vecs[v].exp_bytes[31-8*i -: 8]);
         do_req(vecs[v].fetch, vecs[v].addr, first, cnt);
         if (vecs[v].fetch) check("fetch_latency", 16'(first), 16'd2);
         check("ready_cycles", 16'(cnt), 16'(vecs[v].nbytes));
         check("drained", 16'(exp_q.size()), 16'd0);
         check("no_err", {15'd0, protocol_err}, 16'd0);
      end

      // Store then load back
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      drive(1'b0, 1'b1, 1'b0, 8'h20);
      drive(1'b0, 1'b0, 1'b1, 8'hBE);
      check("wr_lo_state", {13'd0, dbg_state}, {13'd0, WR_LO});
      drive(1'b0, 1'b0, 1'b1, 8'hEF);
      idle_inputs();
      check("store_idle", {13'd0, dbg_state}, {13'd0, IDLE});
      exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
      do_req(1'b0, 16'h0020, first, cnt);
      check("store_load_cnt", 16'(cnt), 16'd2);
      check("store_drained", 16'(exp_q.size()), 16'd0);

      // Preload write colliding with a store to the same word wins
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      drive(1'b0, 1'b1, 1'b0, 8'h50);
      drive(1'b0, 1'b0, 1'b1, 8'h11);
      prog_we = 1'b1; prog_addr = 8'h50; prog_data = 16'h2222;
      drive(1'b0, 1'b0, 1'b1, 8'h11);
      prog_we = 1'b0;
      idle_inputs();
      exp_q.push_back(8'h22); exp_q.push_back(8'h22);
      do_req(1'b0, 16'h0050, first, cnt);
      check("collide_drained", 16'(exp_q.size()), 16'd0);

      // Two strobes together
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      idle_inputs();
      repeat (6) begin @(posedge clk); #1; end
      check("dual_strobe_err", {15'd0, protocol_err}, 16'd1);
      check("dual_strobe_state", {13'd0, dbg_state}, {13'd0, IDLE});

      // Strobe dropped after the first address byte
      do_reset();
      check("err_cleared", {15'd0, protocol_err}, 16'd0);
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      idle_inputs();
      @(posedge clk); #1;
      check("drop_err", {15'd0, protocol_err}, 16'd1);
      check("drop_state", {13'd0, dbg_state}, {13'd0, IDLE});

      // bus_mdr alone in IDLE
      do_reset();
      drive(1'b0, 1'b0, 1'b1, 8'h55);
      idle_inputs();
      check("mdr_alone_err", {15'd0, protocol_err}, 16'd1);

      // Halt during SEND after two bytes
      do_reset();
      exp_q.push_back(8'h12); exp_q.push_back(8'h34);
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 8'h10);
      idle_inputs();
      @(posedge clk); #1;
      @(posedge clk); #1;
      halt = 1'b1;
      check("halt_recv_ready", {15'd0, ard_receive_ready}, 16'd0);
      @(posedge clk); #1;
      check("halt_data_ready", {15'd0, ard_data_ready}, 16'd0);
      check("halt_state", {13'd0, dbg_state}, {13'd0, IDLE});
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      idle_inputs();
      @(posedge clk); #1;
      check("halt_no_err", {15'd0, protocol_err}, 16'd0);
      check("halt_drained", 16'(exp_q.size()), 16'd0);
      halt = 1'b0;
      exp_q.push_back(8'h12); exp_q.push_back(8'h34);
      exp_q.push_back(8'hAB); exp_q.push_back(8'hCD);
      do_req(1'b1, 16'h0010, first, cnt);
      check("post_halt_latency", 16'(first), 16'd2);
      check("post_halt_cnt", 16'(cnt), 16'd4);
      check("post_halt_drained", 16'(exp_q.size()), 16'd0);

      // Asynchronous reset in the WR_LO cycle: no write happens
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      drive(1'b0, 1'b1, 1'b0, 8'h30);
      drive(1'b0, 1'b0, 1'b1, 8'h11);
      bus_mdr = 1'b1; out_bus = 8'h22;
      #2 rst = 1'b0;
      #1;
      check("async_rst_state", {13'd0, dbg_state}, {13'd0, IDLE});
      check("async_rst_ready", {15'd0, ard_data_ready}, 16'd0);
      check("async_rst_in_bus", {8'h00, in_bus}, 16'h0000);
      check("async_rst_recv", {15'd0, ard_receive_ready}, 16'd1);
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      exp_q.push_back(8'hC3); exp_q.push_back(8'hA5);
      do_req(1'b0, 16'h0030, first, cnt);
      check("no_partial_write", 16'(exp_q.size()), 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule

// File: doc/bus_mem_server.md
# bus_mem_server

- Synthesizable stand-in for the external byte-serial host (memory side of the CPU bus).
- Sits directly downstream of the CPU core and also feeds it:
  - consumes the core's `out_bus` bytes, qualified by `bus_pc`, `bus_mar` and `bus_mdr`;
  - serves instruction fetches, loads and stores from an internal word RAM;
  - returns data on `in_bus` with `ard_data_ready`.
- Lets the core run on-chip without the microcontroller.

## Interface
Parameters:
- `ADDR_W`, 8: RAM address width; depth is 2^ADDR_W 16-bit words.
- `RESP_LAT`, 1: wait cycles between request completion and the first response byte. Legal range is 1..15.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `halt`  in  1  core halted; forces the server to IDLE and blocks all traffic.
- `bus_pc`, `bus_mar`, `bus_mdr`  in  1 each  strobe marking which core register is on `out_bus` this cycle.
- `out_bus`  in  8  byte from the core.
- `in_bus`  out  8  response byte to the core; registered.
- `ard_data_ready`  out  1  `in_bus` holds a valid byte; registered.
- `ard_receive_ready`  out  1  server accepts request bytes; combinational from state.
- `prog_we`  in  1  preload write enable.
- `prog_addr`  in  ADDR_W  preload address.
- `prog_data`  in  16  preload word.
- `protocol_err`  out  1  sticky malformed-request flag; cleared only by reset.

## Operation
All words are sent as two bytes, high byte first. Received addresses are 16-bit; only the low ADDR_W bits are used, and addr+1 wraps modulo 2^ADDR_W.

States and transitions:
- **IDLE**
  - Exactly one strobe high: capture `out_bus` as the address high byte, latch kind (FETCH for `bus_pc`, MEM for `bus_mar`), go to ADDR_LO.
  - `bus_mdr` alone: set `protocol_err`, stay in IDLE.
  - Two or more strobes: set `protocol_err`, stay in IDLE.
- **ADDR_LO**
  - Same strobe still high: capture the address low byte.
    - FETCH: go to WAIT with byte count 4.
    - MEM: go to MAR_DECIDE.
  - Strobe missing or different: set `protocol_err`, go to IDLE.
- **MAR_DECIDE**
  - `bus_mdr` high: capture the data high byte, go to WR_LO.
  - Otherwise it is a load: go to WAIT with byte count 2. The cycle is not consumed as data.
- **WR_LO**
  - `bus_mdr` high: capture the data low byte, write RAM[addr] on this edge, go to IDLE.
  - Otherwise: set `protocol_err`, no write, go to IDLE.
- **WAIT**
  - Counter loads RESP_LAT and decrements; at 1, go to SEND.
- **SEND**
  - Drive one byte per consecutive cycle with `ard_data_ready` high.
  - FETCH sends RAM[a] hi, RAM[a] lo, RAM[a+1] hi, RAM[a+1] lo (instruction word plus immediate word).
  - Load sends RAM[a] hi, RAM[a] lo.
  - After the last byte, `ard_data_ready` drops and the state goes to IDLE.

Other rules:
- `ard_receive_ready` = (state is IDLE, ADDR_LO, MAR_DECIDE or WR_LO) and not `halt`.
- Any strobe while in WAIT or SEND sets `protocol_err` and is otherwise ignored; the response continues.
- `halt` high, in any state:
  - next state is IDLE, `ard_data_ready` goes to 0, any pending store is dropped;
  - strobes are ignored and do not set `protocol_err`.
- `prog_we` writes RAM[`prog_addr`] in any state. If it coincides with a store write, the `prog_we` write wins.
- RAM contents are not reset.

## Timing
- Reset values: state IDLE, `in_bus` 8'h00, `ard_data_ready` 0, `protocol_err` 0, byte counter 0. `ard_receive_ready` reads 1 while reset is asserted unless `halt` is high.
- Reset mid-transfer aborts immediately, asynchronously; no partial write occurs.
- Latency: if the last request byte is present in cycle T, the first response byte is valid in cycle T+1+RESP_LAT, and the remaining bytes follow back to back with no gaps.
- Store: the RAM is updated at the end of the cycle carrying the data low byte. A following fetch of that address returns the new value.
- The RAM read is combinational off the latched address. Response bytes are registered, so RAM changes made during SEND may appear in bytes not yet sent.
- A new request is accepted in the cycle after the last response byte.

## Structure
- Shared cpu package holds:
  - `srv_state_t` enum: IDLE, ADDR_LO, MAR_DECIDE, WR_LO, WAIT, SEND;
  - `srv_kind_t` enum: FETCH, MEM;
  - constants `FETCH_BYTES`=4 and `LOAD_BYTES`=2.
- One sub-module, `server_ram`: 2^ADDR_W x 16, one synchronous write port (prog/store mux outside it), two asynchronous read ports (a, a+1).

## Test plan
- Preload RAM[0x10]=0x1234 and RAM[0x11]=0xABCD; `bus_pc` with 0x00, 0x10 -> `in_bus` 0x12, 0x34, 0xAB, 0xCD on 4 consecutive cycles starting at T+2 (RESP_LAT=1); `ard_data_ready` high exactly 4 cycles.
- `bus_mar` with 0x00, 0x20, then `bus_mdr` with 0xBE, 0xEF -> RAM[0x20]=0xBEEF; a following load of 0x0020 (`bus_mar` 0x00, 0x20, no `bus_mdr`) returns 0xBE, 0xEF.
- Address 0x01FF with ADDR_W=8 on fetch -> bytes from RAM[0xFF] then RAM[0x00] (wrap).
- `bus_pc` and `bus_mar` high together -> `protocol_err`=1, no response. Fetch with the strobe dropped after one byte -> `protocol_err`=1, state IDLE.
- `halt` asserted during SEND after 2 bytes -> `ard_data_ready`=0 next cycle, `ard_receive_ready`=0 while halt is high; release -> a new fetch works.
- `rst` low during WR_LO -> no RAM change, outputs at reset values asynchronously.
